// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ write-domain producers.
// Each grant runs a burst of up to MAX_BURST words, stalls on write_full, then re-arbitrates.
module fifo_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                     write_clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     write_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_wr_data,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] next_grant;
    logic [CNT_W-1:0] beat_cnt;
    logic             granted_valid;
    logic             beat;

    // Rotating priority search starting at last+1. Iterating from the far end
    // towards the near end lets the closest requester overwrite the others.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        next_grant = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last) + k) % NUM_REQ]) begin
                next_grant = IDX_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    // Outputs are gated by reset_n so nothing is written in a reset cycle,
    // even when reset lands in the middle of a burst.
    always_comb begin
        granted_valid = req_valid[grant_id];
        busy          = reset_n && (state == BURST);
        beat          = busy && granted_valid && !write_full;
        fifo_wr_en    = beat;
        req_ready     = beat ? (NUM_REQ'(1) << grant_id) : '0;
        fifo_wr_data  = req_data[grant_id*WIDTH +: WIDTH];
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge write_clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant_id <= '0;
            beat_cnt <= '0;
            last     <= IDX_W'(NUM_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= next_grant;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (!granted_valid) begin
                        state <= IDLE;
                        last  <= grant_id;
                    end else if (!write_full) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                            last  <= grant_id;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, single producer, round-robin,
// full stall, early drain and reset in the middle of a burst.
module tb_fifo_write_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    logic                     write_clk;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     write_full;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_wr_data;
    logic [IDX_W-1:0]         grant_id;
    logic                     busy;

    logic [WIDTH-1:0] pdata [NUM_REQ];
    int checks = 0;
    int errors = 0;

    assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

    fifo_write_arbiter #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .MAX_BURST(4)
    ) dut (
        .write_clk    (write_clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .write_full   (write_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge write_clk);
        #2;
    endtask

    task automatic expect_beat(input string tag, input int id);
        #1;
        check({tag, ".wr_en"}, fifo_wr_en, 1);
        check({tag, ".ready"}, req_ready, 32'(1 << id));
        check({tag, ".grant"}, grant_id, id);
        check({tag, ".data"}, fifo_wr_data, pdata[id]);
        check({tag, ".busy"}, busy, 1);
        tick();
        pdata[id] = pdata[id] + 8'd1;
    endtask

    task automatic expect_idle(input string tag, input int id);
        #1;
        check({tag, ".wr_en"}, fifo_wr_en, 0);
        check({tag, ".ready"}, req_ready, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".grant"}, grant_id, id);
        tick();
    endtask

    task automatic expect_stall(input string tag, input int id);
        #1;
        check({tag, ".wr_en"}, fifo_wr_en, 0);
        check({tag, ".ready"}, req_ready, 0);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".grant"}, grant_id, id);
        check({tag, ".data"}, fifo_wr_data, pdata[id]);
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = 4'hF;
        write_full = 1'b0;
        pdata[0] = 8'h80; pdata[1] = 8'h90; pdata[2] = 8'h10; pdata[3] = 8'hB0;

        // 1. reset held for 3 cycles with all producers requesting
        repeat (3) tick();
        #1;
        check("t1.wr_en", fifo_wr_en, 0);
        check("t1.ready", req_ready, 0);
        check("t1.busy", busy, 0);
        check("t1.grant", grant_id, 0);

        // 2. single producer 2: two bursts of 4 with one bubble between
        reset_n   = 1'b1;
        req_valid = 4'b0100;
        expect_idle("t2.arb", 0);
        repeat (4) expect_beat("t2.b1", 2);
        expect_idle("t2.bub", 2);
        repeat (4) expect_beat("t2.b2", 2);
        check("t2.last_data", pdata[2], 8'h18);
        req_valid = 4'b0000;
        expect_idle("t2.end", 2);
        expect_idle("t2.hold", 2);

        // 3. round-robin from reset: grant order 0,1,2,3,0, 5 cycles per grant
        do_reset();
        pdata[0] = 8'hA0; pdata[1] = 8'hB0; pdata[2] = 8'hC0; pdata[3] = 8'hD0;
        req_valid = 4'hF;
        expect_idle("t3.arb", 0);
        for (int n = 0; n < 5; n++) begin
            repeat (4) expect_beat("t3.beat", n % NUM_REQ);
            if (n == 4) req_valid = 4'b0000;
            expect_idle("t3.bub", n % NUM_REQ);
        end
        check("t3.p0_data", pdata[0], 8'hA8);

        // 4. write_full stalls the 2nd beat of producer 1 for 6 cycles
        req_valid = 4'b0010;
        expect_idle("t4.arb", 0);
        expect_beat("t4.b1", 1);
        write_full = 1'b1;
        repeat (6) expect_stall("t4.stall", 1);
        write_full = 1'b0;
        repeat (3) expect_beat("t4.b234", 1);
        req_valid = 4'b0000;
        expect_idle("t4.end", 1);

        // 5. producer 1 drains after 2 beats while producer 3 waits
        req_valid = 4'b0010;
        expect_idle("t5.arb", 1);
        expect_beat("t5.b1", 1);
        req_valid = 4'b1010;
        expect_beat("t5.b2", 1);
        req_valid = 4'b1000;
        expect_stall("t5.drain", 1);
        expect_idle("t5.idle", 1);
        expect_beat("t5.g3", 3);
        req_valid  = 4'b0000;
        write_full = 1'b1;
        expect_stall("t5.drain_full", 3);
        expect_idle("t5.idle_full", 3);
        write_full = 1'b0;

        // 6. reset in the middle of a burst of producer 0
        do_reset();
        pdata[0] = 8'h50;
        req_valid = 4'b0001;
        expect_idle("t6.arb", 0);
        repeat (2) expect_beat("t6.beat", 0);
        reset_n = 1'b0;
        #1;
        check("t6.rst_wr_en", fifo_wr_en, 0);
        check("t6.rst_ready", req_ready, 0);
        check("t6.rst_busy", busy, 0);
        tick();
        #1;
        check("t6.post_wr_en", fifo_wr_en, 0);
        check("t6.post_busy", busy, 0);
        check("t6.post_grant", grant_id, 0);
        tick();
        reset_n   = 1'b1;
        req_valid = 4'b0011;
        expect_idle("t6.rearb", 0);
        check("t6.data_start", pdata[0], 8'h52);
        expect_beat("t6.regrant", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
